// File: rtl/nbit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nbit_adder_pkg
// Shared definitions for the serial N-bit adder: FSM state encoding and
// width helpers used by the top level and the bench.
// -----------------------------------------------------------------------------
package nbit_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int DEF_N = 8;
    localparam int DEF_K = 2;

    // Counter width able to hold 0..m-1; never narrower than one bit.
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nbit_serial_adder_if.sv
// -----------------------------------------------------------------------------
// nbit_serial_adder_if
// Request/result bundle of the serial adder.
//   START, A, B, CIN : request side, driven by the master
//   BUSY, DONE       : status, driven by the adder
//   C, COUT, OVF     : registered result, driven by the adder
// Parameter N must match the N of the adder it is connected to.
// -----------------------------------------------------------------------------
interface nbit_serial_adder_if #(
    parameter int N = 8
) ();

    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] C;
    logic         COUT;
    logic         OVF;

    modport master (
        output START, A, B, CIN,
        input  BUSY, DONE, C, COUT, OVF
    );

    modport slave (
        input  START, A, B, CIN,
        output BUSY, DONE, C, COUT, OVF
    );

endinterface

// File: rtl/nbit_serial_adder_chunk.sv
// -----------------------------------------------------------------------------
// kbit_chunk_adder
// Combinational K-bit adder with carry in and carry out.
//   i_a, i_b : K-bit addends
//   i_cin    : carry in
//   o_sum    : K-bit sum
//   o_cout   : carry out of bit K-1
// -----------------------------------------------------------------------------
module kbit_chunk_adder #(
    parameter int K = 2
) (
    input  logic [K-1:0] i_a,
    input  logic [K-1:0] i_b,
    input  logic         i_cin,
    output logic [K-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{K{1'b0}}, i_cin};

endmodule

// File: rtl/nbit_serial_adder.sv
// -----------------------------------------------------------------------------
// nbit_serial_adder
// Adds two N-bit operands plus carry in, K bits per clock, LSB chunk first.
// Result C/COUT/OVF is loaded on the last chunk edge, M = N/K cycles after
// the START sampling edge, and DONE pulses for one cycle.
//   CLK   : clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : nbit_serial_adder_if.slave (START/A/B/CIN in,
//           BUSY/DONE/C/COUT/OVF out)
// Build option: define NBIT_ADDER_SAT_EN to saturate C to all ones when the
// unsigned sum carries out; COUT and OVF always report the raw result.
// -----------------------------------------------------------------------------
module nbit_serial_adder
    import nbit_adder_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    nbit_serial_adder_if.slave  bus
);

    localparam int M  = (K > 0) ? (N / K) : 1;
    localparam int CW = cnt_w(M);

    generate
        if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_param_err
            $error("nbit_serial_adder: N must be a non-zero multiple of K with K <= N");
        end
    endgenerate

    state_t          r_state;
    state_t          w_next;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_acc;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_c;
    logic            r_cout;
    logic            r_ovf;

    logic [K-1:0]    w_sum;
    logic            w_cout;
    logic            w_last;
    logic [N-1:0]    w_final;
    logic            w_ovf;

    // Operands shift right each chunk, so the active chunk is always [K-1:0].
    kbit_chunk_adder #(.K(K)) u_chunk (
        .i_a    (r_a[K-1:0]),
        .i_b    (r_b[K-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_last  = (r_cnt == CW'(M - 1));
    // New chunk enters at the top of the accumulator; after M chunks the LSB
    // chunk has reached bit 0.
    assign w_final = N'({w_sum, r_acc} >> K);
    // On the last chunk r_a/r_b[K-1] are the original operand sign bits.
    assign w_ovf   = (r_a[K-1] == r_b[K-1]) && (w_sum[K-1] != r_a[K-1]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.START) w_next = BUSY;
            BUSY:    if (w_last)    w_next = DONE;
            DONE:    w_next = bus.START ? BUSY : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY = (r_state == BUSY);
        bus.DONE = (r_state == DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == BUSY) begin
            r_a     <= r_a >> K;
            r_b     <= r_b >> K;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            r_acc   <= w_final;
            if (w_last) begin
`ifdef NBIT_ADDER_SAT_EN
                r_c <= w_cout ? '1 : w_final;
`else
                r_c <= w_final;
`endif
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
        end else if (bus.START) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.CIN;
            r_cnt   <= '0;
            r_acc   <= '0;
        end
    end

    assign bus.C    = r_c;
    assign bus.COUT = r_cout;
    assign bus.OVF  = r_ovf;

endmodule

// File: tb/tb_nbit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nbit_serial_adder
// Scoreboard bench: drivers push expected results into per-DUT queues, and
// monitors pop and compare whenever DONE is seen. One instance at N=8/K=2
// takes directed vectors; one at N=16/K=4 takes back-to-back operations.
// -----------------------------------------------------------------------------
module tb_nbit_serial_adder;

    typedef struct {
        logic [15:0] c;
        logic        cout;
        logic        ovf;
        logic [31:0] t_done;
    } exp_t;

`ifdef NBIT_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst_n;

    exp_t q8[$];
    exp_t q16[$];
    int   n_chk;
    int   n_fail;
    bit   stop16;
    logic [7:0] prev_c8;

    nbit_serial_adder_if #(.N(8))  if8 ();
    nbit_serial_adder_if #(.N(16)) if16 ();

    nbit_serial_adder #(.N(8), .K(2)) u_dut8 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (if8)
    );

    nbit_serial_adder #(.N(16), .K(4)) u_dut16 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] sat8(input logic [7:0] raw, input logic co);
        return (SAT && co) ? 8'hFF : raw;
    endfunction

    function automatic logic [15:0] sat16(input logic [15:0] raw, input logic co);
        return (SAT && co) ? 16'hFFFF : raw;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if8.DONE === 1'b1) begin
            if (q8.size() == 0) begin
                chk("dut8 unexpected DONE", 32'(if8.DONE), 32'd0);
            end else begin
                e = q8.pop_front();
                chk("dut8 C", 32'(if8.C), 32'(e.c[7:0]));
                chk("dut8 COUT", 32'(if8.COUT), 32'(e.cout));
                chk("dut8 OVF", 32'(if8.OVF), 32'(e.ovf));
                chk("dut8 DONE time", 32'($time), e.t_done);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   f0;
        if (rst_n && if16.DONE === 1'b1) begin
            f0 = n_fail;
            if (q16.size() == 0) begin
                chk("dut16 unexpected DONE", 32'(if16.DONE), 32'd0);
            end else begin
                e = q16.pop_front();
                chk("dut16 C", 32'(if16.C), 32'(e.c));
                chk("dut16 COUT", 32'(if16.COUT), 32'(e.cout));
                chk("dut16 OVF", 32'(if16.OVF), 32'(e.ovf));
                chk("dut16 DONE time", 32'($time), e.t_done);
            end
            if (n_fail != f0) stop16 = 1'b1;
        end
    end

    // Directed N=8 operation; poke re-pulses START with A=AA mid-operation.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] ec, input logic ecout, input logic eovf,
                       input bit poke);
        exp_t e;
        @(negedge clk);
        if8.START = 1'b1;
        if8.A     = a;
        if8.B     = b;
        if8.CIN   = cin;
        e.c      = {8'h00, sat8(ec, ecout)};
        e.cout   = ecout;
        e.ovf    = eovf;
        e.t_done = 32'($time) + 32'd50;
        q8.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("dut8 BUSY in op", 32'(if8.BUSY), 32'd1);
            chk("dut8 DONE in op", 32'(if8.DONE), 32'd0);
            chk("dut8 C held in op", 32'(if8.C), 32'(prev_c8));
            if (i == 1) if8.START = 1'b0;
            if (i == 2 && poke) begin
                if8.START = 1'b1;
                if8.A     = 8'hAA;
            end
            if (i == 3) if8.START = 1'b0;
        end
        @(negedge clk);
        chk("dut8 DONE at end", 32'(if8.DONE), 32'd1);
        chk("dut8 BUSY at end", 32'(if8.BUSY), 32'd0);
        @(negedge clk);
        chk("dut8 DONE after pulse", 32'(if8.DONE), 32'd0);
        chk("dut8 BUSY after pulse", 32'(if8.BUSY), 32'd0);
        chk("dut8 queue drained", 32'(q8.size()), 32'd0);
        prev_c8 = sat8(ec, ecout);
    endtask

    task automatic issue16();
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] s;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        s   = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        if16.START = 1'b1;
        if16.A     = a;
        if16.B     = b;
        if16.CIN   = cin;
        e.c      = sat16(s[15:0], s[16]);
        e.cout   = s[16];
        e.ovf    = (a[15] == b[15]) && (s[15] != a[15]);
        e.t_done = 32'($time) + 32'd49;
        q16.push_back(e);
    endtask

    task automatic run16();
        int to;
        @(negedge clk);
        #1;
        for (int k = 0; k < 100; k++) begin
            issue16();
            @(negedge clk);
            if16.START = 1'b0;
            to = 1;
            while (if16.DONE !== 1'b1 && to < 20) begin
                @(negedge clk);
                to++;
            end
            if (if16.DONE !== 1'b1) begin
                chk("dut16 DONE timeout", 32'(if16.DONE), 32'd1);
                break;
            end
            #1;
            if (stop16) break;
        end
        repeat (8) @(negedge clk);
        if (stop16) q16.delete();
        else chk("dut16 queue drained", 32'(q16.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        stop16  = 1'b0;
        prev_c8 = 8'h00;
        rst_n   = 1'b0;
        if8.START  = 1'b0;
        if8.A      = '0;
        if8.B      = '0;
        if8.CIN    = 1'b0;
        if16.START = 1'b0;
        if16.A     = '0;
        if16.B     = '0;
        if16.CIN   = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset BUSY", 32'(if8.BUSY), 32'd0);
        chk("reset DONE", 32'(if8.DONE), 32'd0);
        chk("reset C", 32'(if8.C), 32'd0);
        chk("reset COUT", 32'(if8.COUT), 32'd0);
        chk("reset OVF", 32'(if8.OVF), 32'd0);
        chk("reset dut16 C", 32'(if16.C), 32'd0);
        rst_n = 1'b1;

        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        op8(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        op8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        op8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("dut8 no second DONE", 32'(if8.DONE), 32'd0);

        // Abort an operation with reset in its second cycle.
        @(negedge clk);
        if8.START = 1'b1;
        if8.A     = 8'h5A;
        if8.B     = 8'h11;
        if8.CIN   = 1'b0;
        @(negedge clk);
        if8.START = 1'b0;
        chk("abort BUSY before reset", 32'(if8.BUSY), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort BUSY", 32'(if8.BUSY), 32'd0);
        chk("abort DONE", 32'(if8.DONE), 32'd0);
        chk("abort C", 32'(if8.C), 32'd0);
        chk("abort COUT", 32'(if8.COUT), 32'd0);
        chk("abort OVF", 32'(if8.OVF), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_c8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort no DONE", 32'(if8.DONE), 32'd0);
        end
        op8(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);

        run16();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nbit_serial_adder.md
NBIT_SERIAL_ADDER -- requirements
Module: nbit_serial_adder

Interface
REQ-001 SHALL have parameter N, default 8, operand and result width in bits.
REQ-002 SHALL have parameter K, default 2, chunk width added per cycle.
REQ-003 SHALL have CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have START  input  1  request to begin an addition; A, B and CIN are sampled with it.
REQ-006 SHALL have A  input  N  first operand.
REQ-007 SHALL have B  input  N  second operand.
REQ-008 SHALL have CIN  input  1  carry in.
REQ-009 SHALL have BUSY  output  1  high while chunks are being processed.
REQ-010 SHALL have DONE  output  1  one-cycle pulse when the result is valid.
REQ-011 SHALL have C  output  N  sum, registered.
REQ-012 SHALL have COUT  output  1  unsigned carry out of bit N-1.
REQ-013 SHALL have OVF  output  1  two's-complement overflow flag.

Function
REQ-014 SHALL use FSM states IDLE, BUSY and DONE, with M = N/K chunk cycles per operation.
REQ-015 IDLE or DONE with START=1 at edge e0 SHALL capture A, B and CIN, clear the chunk counter, enter BUSY and set BUSY=1.
REQ-016 At edges e1..eM, chunk i SHALL be added, LSB chunk first, with the carry taken from a carry register; the chunk result SHALL be shifted into an internal result register.
REQ-017 At edge eM the FSM SHALL enter DONE and load C, COUT and OVF, with DONE=1 and BUSY=0 for exactly one cycle.
REQ-018 DONE without START SHALL return to IDLE on the next edge, with DONE=0.
REQ-019 START in DONE SHALL begin a new operation back-to-back per REQ-015, and DONE SHALL drop.
REQ-020 Result latency SHALL be M cycles from the START sampling edge to DONE high.
REQ-021 START while BUSY SHALL be ignored; the operands of the operation in progress SHALL stay unchanged.
REQ-022 C, COUT and OVF SHALL hold their values until the next completion or reset, and SHALL NOT change during BUSY.
REQ-023 The full result SHALL equal (A + B + CIN) mod 2^N, with COUT the bit-N carry.
REQ-024 OVF SHALL be 1 when A[N-1]==B[N-1] and the unsaturated sum[N-1]!=A[N-1]; otherwise 0.
REQ-025 A parameter set with N % K != 0 or K > N SHALL cause an elaboration error.

Reset
REQ-026 RST_N=0 SHALL immediately force state IDLE, BUSY=0, DONE=0, C=0, COUT=0, OVF=0, and clear all internal registers.
REQ-027 Reset during BUSY SHALL abort the operation with no DONE pulse; the first START after RST_N rises SHALL operate normally.

Configuration
REQ-028 Macro NBIT_ADDER_SAT_EN defined: when COUT=1 at completion, C SHALL be all ones (unsigned saturation); COUT and OVF SHALL still report the raw values.
REQ-029 Macro NBIT_ADDER_SAT_EN undefined: C SHALL wrap modulo 2^N.

Structure
REQ-030 Package nbit_adder_pkg SHALL hold the FSM state typedef (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and shared width helper constants.
REQ-031 The design SHALL use one sub-module, kbit_chunk_adder: a combinational K-bit adder with carry in and carry out, instantiated once.

Verification (N=8, K=2, M=4 unless stated)
REQ-032 A=8'h0F, B=8'h01, CIN=0 -> C=8'h10, COUT=0, OVF=0; DONE high exactly 4 cycles after the START edge, BUSY high for those 4 cycles.
REQ-033 A=8'hFF, B=8'h01, CIN=0 -> C=8'h00, COUT=1, OVF=0; with NBIT_ADDER_SAT_EN -> C=8'hFF, COUT=1.
REQ-034 A=8'h7F, B=8'h00, CIN=1 -> C=8'h80, COUT=0, OVF=1.
REQ-035 START with A=8'h11, B=8'h22, then START pulsed again in cycle 2 with A=8'hAA -> C=8'h33; single DONE pulse.
REQ-036 RST_N=0 in cycle 2 of an operation -> BUSY=0, C=0, no DONE pulse; the next START with A=8'h05, B=8'h03 -> C=8'h08.
REQ-037 N=16, K=4: 100 random operations issued back-to-back on DONE -> every C/COUT matches A+B+CIN and OVF matches REQ-024; the bench SHALL stop on the first mismatch.
